// File: rtl/jtframe_rom_arb_pkg.sv
// jtframe_rom_arb_pkg: shared FSM encoding and round-robin grant selection for the ROM arbiter
package jtframe_rom_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, WAIT_DATA = 2'd2} state_t;
    localparam int MAXREQ = 4;
    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] last, input int nreq);
        logic [1:0] idx;
        logic [1:0] g;
        logic found;
        idx = last;
        g = last;
        found = 1'b0;
        for (int k = 0; k < MAXREQ; k++) begin
            if (k < nreq) begin
                idx = (int'(idx) == nreq - 1) ? 2'd0 : idx + 2'd1;
                if (pend[idx] && !found) begin
                    g = idx;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction
endpackage

// File: rtl/jtframe_rom_arb_slot.sv
// jtframe_rom_arb_slot: one-entry read cache with hit detection for a single requester
module jtframe_rom_arb_slot #(
    parameter int AW = 20,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    input  logic          i_fill,
    input  logic [AW-1:0] i_fill_addr,
    input  logic [DW-1:0] i_fill_data,
    output logic          o_ok,
    output logic [DW-1:0] o_dout
);
    logic          r_valid;
    logic [AW-1:0] r_tag;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_addr;
            r_data  <= i_fill_data;
        end
    end

    assign o_ok   = i_cs & r_valid & (r_tag == i_addr);
    assign o_dout = r_data;
endmodule

// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb: round-robin sharing of one SDRAM ROM read port with per-requester caches and a watchdog
module jtframe_rom_arb
    import jtframe_rom_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 20,
    parameter int DW   = 8,
    parameter int TOW  = 8
) (
    input  logic              rst_n,
    input  logic              clk,
    input  logic [NREQ-1:0]   i_req_cs,
    input  logic [NREQ*AW-1:0] i_req_addr,
    output logic [NREQ*DW-1:0] o_req_dout,
    output logic [NREQ-1:0]   o_req_ok,
    output logic              o_sdram_req,
    output logic [AW-1:0]     o_sdram_addr,
    input  logic              i_sdram_ack,
    input  logic              i_sdram_dok,
    input  logic [DW-1:0]     i_sdram_din,
    output logic              o_timeout
);
    state_t          r_state;
    logic [1:0]      r_grant;
    logic [1:0]      r_last;
    logic [AW-1:0]   r_addr;
    logic            r_req;
    logic            r_timeout;
    logic [TOW-1:0]  r_cnt;
    logic [NREQ-1:0] w_ok;
    logic [NREQ-1:0] w_pend;
    logic [NREQ-1:0] w_fill;
    logic [AW-1:0]   w_addr [NREQ];
    logic [3:0]      w_pend4;
    logic [1:0]      w_pick;
    logic [AW-1:0]   w_pick_addr;
    logic            w_done;

    assign w_pend = i_req_cs & ~w_ok;
    assign w_done = (r_state == WAIT_ACK && i_sdram_ack && i_sdram_dok) || (r_state == WAIT_DATA && i_sdram_dok);

    always_comb begin
        w_pend4 = '0;
        w_pend4[NREQ-1:0] = w_pend;
        w_pick = rr_pick(w_pend4, r_last, NREQ);
        w_pick_addr = '0;
        for (int k = 0; k < NREQ; k++)
            if (w_pick == 2'(k)) w_pick_addr = w_addr[k];
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign w_addr[i] = i_req_addr[i*AW +: AW];
        assign w_fill[i] = w_done && (r_grant == 2'(i));
        jtframe_rom_arb_slot #(.AW(AW), .DW(DW)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_cs       (i_req_cs[i]),
            .i_addr     (w_addr[i]),
            .i_fill     (w_fill[i]),
            .i_fill_addr(r_addr),
            .i_fill_data(i_sdram_din),
            .o_ok       (w_ok[i]),
            .o_dout     (o_req_dout[i*DW +: DW])
        );
    end

    // completion outranks ack, which outranks the watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_last    <= 2'(NREQ - 1);
            r_addr    <= '0;
            r_req     <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|w_pend) begin
                    r_grant <= w_pick;
                    r_addr  <= w_pick_addr;
                    r_req   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= WAIT_ACK;
                end
                WAIT_ACK, WAIT_DATA: begin
                    r_cnt <= r_cnt + TOW'(1);
                    if (w_done) begin
                        r_req   <= 1'b0;
                        r_last  <= r_grant;
                        r_state <= IDLE;
                    end else if (r_state == WAIT_ACK && i_sdram_ack) begin
                        r_req   <= 1'b0;
                        r_state <= WAIT_DATA;
                    end else if (&r_cnt) begin
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_last    <= r_grant;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ok     = w_ok;
    assign o_sdram_req  = r_req;
    assign o_sdram_addr = r_addr;
    assign o_timeout    = r_timeout;
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// tb_jtframe_rom_arb: directed scoreboard bench for the ROM arbiter
module tb_jtframe_rom_arb;
    localparam int NREQ = 2;
    localparam int AW   = 20;
    localparam int DW   = 8;
    localparam int TOW  = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    i_req_cs = '0;
    logic [NREQ*AW-1:0] i_req_addr = '0;
    logic [NREQ*DW-1:0] o_req_dout;
    logic [NREQ-1:0]    o_req_ok;
    logic               o_sdram_req;
    logic [AW-1:0]      o_sdram_addr;
    logic               i_sdram_ack = 1'b0;
    logic               i_sdram_dok = 1'b0;
    logic [DW-1:0]      i_sdram_din = '0;
    logic               o_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] mon_exp;
    logic prev_req = 1'b0;

    jtframe_rom_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TOW(TOW)) dut (
        .rst_n       (rst_n),
        .clk         (clk),
        .i_req_cs    (i_req_cs),
        .i_req_addr  (i_req_addr),
        .o_req_dout  (o_req_dout),
        .o_req_ok    (o_req_ok),
        .o_sdram_req (o_sdram_req),
        .o_sdram_addr(o_sdram_addr),
        .i_sdram_ack (i_sdram_ack),
        .i_sdram_dok (i_sdram_dok),
        .i_sdram_din (i_sdram_din),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // every new SDRAM request must match the next queued address
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) prev_req = 1'b0;
        else begin
            if (o_sdram_req && !prev_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_req actual=%h required=none", o_sdram_addr);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (o_sdram_addr !== mon_exp) begin
                        failures++;
                        $display("FAIL req_addr actual=%h required=%h", o_sdram_addr, mon_exp);
                    end
                end
            end
            prev_req = o_sdram_req;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_addr(input int r, input logic [AW-1:0] a);
        i_req_addr[r*AW +: AW] = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req_cs = '0;
        i_sdram_ack = 1'b0;
        i_sdram_dok = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!o_sdram_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!o_sdram_req) begin
            failures++;
            $display("FAIL wait_req actual=no_request required=request");
        end
    endtask

    task automatic ack_in(input int n);
        repeat (n) @(negedge clk);
        i_sdram_ack = 1'b1;
        @(negedge clk);
        i_sdram_ack = 1'b0;
    endtask

    task automatic dok_in(input int n, input logic [DW-1:0] d);
        repeat (n) @(negedge clk);
        i_sdram_dok = 1'b1;
        i_sdram_din = d;
        @(negedge clk);
        i_sdram_dok = 1'b0;
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        chk("reset_ok", 32'(o_req_ok), 0);
        chk("reset_req", 32'(o_sdram_req), 0);
        chk("reset_addr", 32'(o_sdram_addr), 0);
        chk("reset_dout", 32'(o_req_dout), 0);
        chk("reset_timeout", 32'(o_timeout), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // hit path
        set_addr(0, 20'h01234);
        i_req_cs[0] = 1'b1;
        exp_q.push_back(20'h01234);
        wait_req();
        chk("hit_ok_pending", 32'(o_req_ok[0]), 0);
        ack_in(2);
        chk("hit_req_dropped", 32'(o_sdram_req), 0);
        chk("hit_addr_stable", 32'(o_sdram_addr), 32'h01234);
        dok_in(2, 8'h5A);
        chk("hit_ok", 32'(o_req_ok[0]), 1);
        chk("hit_dout", 32'(o_req_dout[7:0]), 32'h5A);
        i_req_cs[0] = 1'b0;
        @(negedge clk);
        chk("hit_ok_cs_low", 32'(o_req_ok[0]), 0);
        i_req_cs[0] = 1'b1;
        @(negedge clk);
        chk("rehit_ok", 32'(o_req_ok[0]), 1);
        repeat (3) @(negedge clk);
        chk("rehit_no_req", 32'(o_sdram_req), 0);

        // round robin
        do_reset();
        set_addr(0, 20'h00010);
        set_addr(1, 20'h00020);
        i_req_cs = 2'b11;
        exp_q.push_back(20'h00010);
        wait_req();
        i_req_cs[1] = 1'b0;
        ack_in(1);
        dok_in(1, 8'hA1);
        chk("rr0_ok", 32'(o_req_ok), 32'b01);
        chk("rr0_dout", 32'(o_req_dout[7:0]), 32'hA1);
        repeat (2) @(negedge clk);
        chk("rr_idle", 32'(o_sdram_req), 0);
        set_addr(0, 20'h00030);
        i_req_cs = 2'b11;
        exp_q.push_back(20'h00020);
        exp_q.push_back(20'h00030);
        wait_req();
        ack_in(1);
        dok_in(1, 8'hB2);
        chk("rr1_ok", 32'(o_req_ok[1]), 1);
        chk("rr1_dout", 32'(o_req_dout[15:8]), 32'hB2);
        wait_req();
        ack_in(1);
        dok_in(1, 8'hB3);
        chk("rr2_ok", 32'(o_req_ok), 32'b11);
        chk("rr2_dout", 32'(o_req_dout[7:0]), 32'hB3);

        // combined ack and dok
        do_reset();
        set_addr(0, 20'h00200);
        i_req_cs = 2'b01;
        exp_q.push_back(20'h00200);
        wait_req();
        @(negedge clk);
        i_sdram_ack = 1'b1;
        i_sdram_dok = 1'b1;
        i_sdram_din = 8'hC3;
        @(negedge clk);
        i_sdram_ack = 1'b0;
        i_sdram_dok = 1'b0;
        chk("comb_ok", 32'(o_req_ok[0]), 1);
        chk("comb_dout", 32'(o_req_dout[7:0]), 32'hC3);
        chk("comb_req", 32'(o_sdram_req), 0);
        repeat (3) @(negedge clk);
        chk("comb_no_extra", 32'(o_sdram_req), 0);

        // address change during WAIT_DATA
        do_reset();
        set_addr(0, 20'h00100);
        i_req_cs = 2'b01;
        exp_q.push_back(20'h00100);
        wait_req();
        ack_in(1);
        set_addr(0, 20'h00104);
        exp_q.push_back(20'h00104);
        dok_in(2, 8'h11);
        chk("chg_ok_low", 32'(o_req_ok[0]), 0);
        chk("chg_old_data", 32'(o_req_dout[7:0]), 32'h11);
        wait_req();
        ack_in(1);
        dok_in(1, 8'h22);
        chk("chg_new_ok", 32'(o_req_ok[0]), 1);
        chk("chg_new_dout", 32'(o_req_dout[7:0]), 32'h22);

        // watchdog timeout
        do_reset();
        set_addr(1, 20'h00777);
        i_req_cs = 2'b10;
        exp_q.push_back(20'h00777);
        wait_req();
        t0 = cyc;
        ack_in(1);
        while (!o_timeout && cyc - t0 < 400) @(negedge clk);
        chk("to_flag", 32'(o_timeout), 1);
        checks++;
        if (cyc - t0 < 255 || cyc - t0 > 257) begin
            failures++;
            $display("FAIL to_latency actual=%0d required=255..257", cyc - t0);
        end
        chk("to_req_low", 32'(o_sdram_req), 0);
        chk("to_ok_low", 32'(o_req_ok[1]), 0);
        exp_q.push_back(20'h00777);
        wait_req();
        ack_in(0);
        dok_in(1, 8'h77);
        chk("to_refill_ok", 32'(o_req_ok[1]), 1);
        chk("to_refill_dout", 32'(o_req_dout[15:8]), 32'h77);
        chk("to_sticky", 32'(o_timeout), 1);

        // asynchronous reset during WAIT_DATA
        set_addr(0, 20'h00900);
        i_req_cs = 2'b11;
        exp_q.push_back(20'h00900);
        wait_req();
        ack_in(1);
        chk("rst_pre_ok1", 32'(o_req_ok[1]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ok", 32'(o_req_ok), 0);
        chk("rst_req", 32'(o_sdram_req), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        i_req_cs = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
